// File: rtl/aes_key_pkg.sv
// Shared encodings and helpers for the runtime-selectable AES key schedule.
// Key-size codes, Nk/Nr lookups, GF(2^8) xtime and the expander state type.
package aes_key_pkg;

  localparam logic [1:0] KEY_SIZE_128     = 2'b00;
  localparam logic [1:0] KEY_SIZE_192     = 2'b01;
  localparam logic [1:0] KEY_SIZE_256     = 2'b10;
  localparam logic [1:0] KEY_SIZE_ILLEGAL = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } ke_state_t;

  function automatic logic [3:0] nk_of(input logic [1:0] ks);
    logic [3:0] n;
    case (ks)
      KEY_SIZE_192: n = 4'd6;
      KEY_SIZE_256: n = 4'd8;
      default:      n = 4'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    logic [3:0] n;
    case (ks)
      KEY_SIZE_192: n = 4'd12;
      KEY_SIZE_256: n = 4'd14;
      default:      n = 4'd10;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_ke_word_gen.sv
// One key-schedule word step: w[i] = w[i-Nk] ^ t(w[i-1]), purely combinational.
// rot_en selects RotWord+SubWord+rcon, sub_en alone selects SubWord only.
module aes_ke_word_gen
  import aes_key_pkg::*;
(
  input  logic [31:0] prev_word,
  input  logic [31:0] period_word,
  input  logic        rot_en,
  input  logic        sub_en,
  input  logic [7:0]  rcon,
  output logic [31:0] word
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the byte offset is the inverted input.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [31:0] t;

  always_comb begin
    t = rot_en ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (sub_en) t = sub_word(t);
    if (rot_en) t = t ^ {rcon, 24'h000000};
    word = period_word ^ t;
  end

endmodule

// File: rtl/aes_key_expansion_param.sv
// AES-128/192/256 key schedule streaming Nr+1 round keys, round key 0 one cycle after start,
// then one key per cycle; rk_data/rk_idx/rk_last hold while rk_valid && !rk_ready.
module aes_key_expansion_param
  import aes_key_pkg::*;
#(
  parameter int KEY_W    = 256,
  parameter int WORDS_PB = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       key_size,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_idx,
  output logic             rk_last,
  output logic             err
);

  ke_state_t state, state_nxt;
  logic      load_en, step_en, done_en, err_set;

  logic [3:0]  nk_q, nr_q, wrap_q;
  logic [7:0]  rcon_q;
  logic [31:0] hist_q    [8];
  logic [31:0] hist_load [8];
  logic [31:0] hist_step [8];

  logic [255:0] key_full, key_sh;
  logic [3:0]   load_off;
  logic [31:0]  gen_word [WORDS_PB];
  logic [WORDS_PB-1:0] gen_rot;
  logic [3:0]   wrap_raw, wrap_step;
  logic [7:0]   rcon_step;
  logic [127:0] rk_step;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    step_en   = 1'b0;
    done_en   = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (key_size == KEY_SIZE_ILLEGAL) begin
            err_set = 1'b1;
          end else begin
            load_en   = 1'b1;
            state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (rk_ready) begin
          if (rk_last) begin
            done_en   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            step_en = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (state == S_STREAM);
  assign rk_valid = (state == S_STREAM);

  // ---------------- key load ----------------
  // The window always ends at the newest word; a fresh key fills the top Nk slots.
  assign key_full = 256'(key) << (256 - KEY_W);
  assign load_off = 4'd8 - nk_of(key_size);
  assign key_sh   = key_full >> {load_off, 5'b00000};

  always_comb begin
    for (int p = 0; p < 8; p++) hist_load[p] = key_sh[255-32*p -: 32];
  end

  // ---------------- one beat of word generation ----------------
  for (genvar j = 0; j < WORDS_PB; j++) begin : g_word
    logic [3:0]  cnt_raw, cnt;
    logic [31:0] prev_w, period_w, word_out;

    assign cnt_raw    = wrap_q + 4'(j);
    assign cnt        = (cnt_raw >= nk_q) ? cnt_raw - nk_q : cnt_raw;
    assign gen_rot[j] = (cnt == 4'd0);
    // w[i-Nk] is always Nk slots behind the newest word, i.e. at slot 8-Nk+j.
    assign period_w   = (nk_q == 4'd8) ? hist_q[j]   :
                        (nk_q == 4'd6) ? hist_q[j+2] : hist_q[j+4];

    if (j == 0) begin : g_first
      assign prev_w = hist_q[7];
    end else begin : g_chain
      assign prev_w = gen_word[j-1];
    end

    aes_ke_word_gen u_word_gen (
      .prev_word   (prev_w),
      .period_word (period_w),
      .rot_en      (gen_rot[j]),
      .sub_en      (gen_rot[j] || (nk_q == 4'd8 && cnt == 4'd4)),
      .rcon        (rcon_q),
      .word        (word_out)
    );

    assign gen_word[j] = word_out;
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      hist_step[p]   = hist_q[p+4];
      hist_step[p+4] = gen_word[p];
    end
  end

  assign wrap_raw  = wrap_q + 4'(WORDS_PB);
  assign wrap_step = (wrap_raw >= nk_q) ? wrap_raw - nk_q : wrap_raw;
  // Nk >= 4 guarantees at most one rcon-consuming word per beat.
  assign rcon_step = (|gen_rot) ? xtime(rcon_q) : rcon_q;

  // Round key r always lands at slots 8-Nk .. 11-Nk of the window.
  always_comb begin
    case (nk_q)
      4'd8:    rk_step = {hist_step[0], hist_step[1], hist_step[2], hist_step[3]};
      4'd6:    rk_step = {hist_step[2], hist_step[3], hist_step[4], hist_step[5]};
      default: rk_step = {hist_step[4], hist_step[5], hist_step[6], hist_step[7]};
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nk_q    <= 4'd0;
      nr_q    <= 4'd0;
      wrap_q  <= 4'd0;
      rcon_q  <= 8'h00;
      rk_data <= 128'h0;
      rk_idx  <= 4'd0;
      rk_last <= 1'b0;
      err     <= 1'b0;
      for (int p = 0; p < 8; p++) hist_q[p] <= 32'h0;
    end else begin
      err <= err_set;
      if (load_en) begin
        nk_q    <= nk_of(key_size);
        nr_q    <= nr_of(key_size);
        wrap_q  <= 4'd0;
        rcon_q  <= 8'h01;
        hist_q  <= hist_load;
        rk_data <= key_full[255:128];
        rk_idx  <= 4'd0;
        rk_last <= 1'b0;
      end else if (step_en) begin
        hist_q  <= hist_step;
        wrap_q  <= wrap_step;
        rcon_q  <= rcon_step;
        rk_data <= rk_step;
        rk_idx  <= rk_idx + 4'd1;
        rk_last <= ((rk_idx + 4'd1) == nr_q);
      end else if (done_en) begin
        rk_data <= 128'h0;
        rk_idx  <= 4'd0;
        rk_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expansion_param.sv
// Bench for the AES key schedule: FIPS-197 vectors plus random keys/backpressure,
// checked against a word-level FIPS-197 model built from GF(2^8) arithmetic.
module tb_aes_key_expansion_param;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hdeadbeefcafef00d};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  mw [60];
  logic [127:0] first_rk, last_rk;

  aes_key_expansion_param dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_size (key_size),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .rk_last  (rk_last),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] a);
    logic [7:0] inv, sq;
    inv = 8'h01;
    sq  = a;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    if (a == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] x);
    return {m_sbox(x[31:24]), m_sbox(x[23:16]), m_sbox(x[15:8]), m_sbox(x[7:0])};
  endfunction

  task automatic build_model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        mw[i] = k[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          rc = 8'h01;
          for (int q = 1; q < i / nk; q++) rc = gmul(rc, 8'h02);
          t = m_subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        end else if (nk == 8 && i % nk == 4) begin
          t = m_subw(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  // ---------------- one expansion run ----------------
  task automatic run_stream(input logic [1:0] ks, input logic [255:0] k, input int ready_pct,
                            input int abort_at, input bit poke);
    int nk, nr, beat, cyc;
    logic [127:0] held;
    bit held_vld;
    nk = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
    nr = nk + 6;
    build_model(k, nk);
    start    = 1'b1;
    key_size = ks;
    key      = k;
    @(negedge clk);
    start = 1'b0;
    key   = ~k;
    key_size = 2'b00;
    check("busy_after_start", 128'(busy), 128'd1);
    beat = 0;
    cyc  = 0;
    held_vld = 1'b0;
    while (beat <= nr && cyc < 500) begin
      check("rk_valid", 128'(rk_valid), 128'd1);
      check("no_err_streaming", 128'(err), 128'd0);
      if (!rk_valid) break;
      if (held_vld) check("stall_stable", rk_data, held);
      if (beat == abort_at) begin
        rk_ready = 1'b0;
        reset    = 1'b0;
        #1;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_valid", 128'(rk_valid), 128'd0);
        check("abort_data", rk_data, 128'd0);
        check("abort_idx", 128'(rk_idx), 128'd0);
        check("abort_last", 128'(rk_last), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      if (poke && (beat == 3 || beat == 4)) begin
        start    = 1'b1;
        key_size = (beat == 3) ? 2'b11 : 2'b00;
      end else begin
        start = 1'b0;
      end
      rk_ready = ($urandom_range(99) < ready_pct);
      if (rk_ready) begin
        check("rk_data", rk_data, {mw[4*beat], mw[4*beat+1], mw[4*beat+2], mw[4*beat+3]});
        check("rk_idx", 128'(rk_idx), 128'(beat));
        check("rk_last", 128'(rk_last), 128'(beat == nr));
        if (beat == 0) first_rk = rk_data;
        last_rk  = rk_data;
        beat++;
        held_vld = 1'b0;
      end else begin
        held     = rk_data;
        held_vld = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    start    = 1'b0;
    check("beat_count", 128'(beat), 128'(nr + 1));
    check("busy_low_after", 128'(busy), 128'd0);
    check("valid_low_after", 128'(rk_valid), 128'd0);
    check("data_zero_after", rk_data, 128'd0);
    check("err_after", 128'(err), 128'd0);
  endtask

  initial begin
    logic [255:0] kv;
    reset    = 1'b0;
    start    = 1'b0;
    key_size = 2'b00;
    key      = '0;
    rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_data", rk_data, 128'd0);
    check("rst_idx", 128'(rk_idx), 128'd0);
    check("rst_last", 128'(rk_last), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    reset = 1'b1;
    @(negedge clk);

    run_stream(2'b00, KEY128, 100, -1, 1'b0);
    check("kat128_last", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_stream(2'b01, KEY192, 100, -1, 1'b0);
    check("kat192_last", last_rk, 128'he98ba06f448c773c8ecc720401002202);
    run_stream(2'b10, KEY256, 100, -1, 1'b0);
    check("kat256_last", last_rk, 128'hfe4890d1e6188d0b046df344706c631e);

    // backpressure plus start pokes while streaming
    run_stream(2'b01, KEY192, 40, -1, 1'b1);
    check("bp192_last", last_rk, 128'he98ba06f448c773c8ecc720401002202);

    // illegal key size in IDLE
    start    = 1'b1;
    key_size = 2'b11;
    key      = KEY256;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 128'(err), 128'd1);
    check("err_busy", 128'(busy), 128'd0);
    check("err_valid", 128'(rk_valid), 128'd0);
    @(negedge clk);
    check("err_one_cycle", 128'(err), 128'd0);
    check("err_busy_later", 128'(busy), 128'd0);

    // reset at beat 5 of AES-256, then a clean AES-128 run
    run_stream(2'b10, KEY256, 100, 5, 1'b0);
    run_stream(2'b00, KEY128, 100, -1, 1'b0);
    kv = KEY128;
    check("rk0_after_reset", first_rk, kv[255:128]);
    check("kat128_after_reset", last_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int n = 0; n < 8; n++) begin
      kv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_stream(2'(($urandom_range(2))), kv, $urandom_range(100, 30), -1, n[0]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
